// File: rtl/sra_reg_slave.sv
// SRA register-file slave: NUM_REGS registers, one-deep response slot, hw side write port.
// Define SRA_REG_WRITE_ACK_EN to acknowledge writes; otherwise writes are posted with no response.
module sra_reg_slave #(
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int ADDR_WIDTH       = 8,
  parameter int M_USER_BITS      = 2,
  parameter int S_USER_BITS      = 2,
  parameter int NUM_REGS         = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               m_valid,
  output logic                               m_ready,
  input  logic [DATA_WIDTH_BYTES*8-1:0]      m_data,
  input  logic [M_USER_BITS-1:0]             m_user,
  input  logic [ADDR_WIDTH-1:0]              m_addr,
  output logic                               s_valid,
  input  logic                               s_ready,
  output logic [DATA_WIDTH_BYTES*8-1:0]      s_data,
  output logic [S_USER_BITS-1:0]             s_user,
  output logic [ADDR_WIDTH-1:0]              s_addr,
  input  logic                               hw_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]        hw_wr_addr,
  input  logic [DATA_WIDTH_BYTES*8-1:0]      hw_wr_data,
  output logic [NUM_REGS*DATA_WIDTH_BYTES*8-1:0] reg_q,
  output logic [NUM_REGS-1:0]                bus_wr_pulse
);

  localparam int DW = DATA_WIDTH_BYTES * 8;
  localparam int IW = $clog2(NUM_REGS);

`ifdef SRA_REG_WRITE_ACK_EN
  localparam bit WRITE_ACK = 1'b1;
`else
  localparam bit WRITE_ACK = 1'b0;
`endif

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

  slot_t                   slot_q, slot_d;
  logic [DW-1:0]           s_data_q, s_data_d;
  logic [S_USER_BITS-1:0]  s_user_q, s_user_d;
  logic [ADDR_WIDTH-1:0]   s_addr_q, s_addr_d;
  logic [DW-1:0]           regs_q [NUM_REGS];
  logic [DW-1:0]           regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     pulse_q, pulse_d;

  logic                    accept;
  logic                    is_wr;
  logic                    in_range;
  logic                    resp_en;
  logic [IW-1:0]           idx;
  logic [DW-1:0]           rd_data;
  logic                    unused_m_user;

  assign s_valid  = (slot_q == SLOT_FULL);
  assign m_ready  = !s_valid || s_ready;
  assign accept   = m_valid && m_ready;
  assign is_wr    = m_user[0];
  assign in_range = {1'b0, m_addr} < (ADDR_WIDTH+1)'(NUM_REGS);
  assign idx      = m_addr[IW-1:0];
  assign resp_en  = accept && (WRITE_ACK || !is_wr);
  assign unused_m_user = ^m_user;

  // A hw write landing on the accept edge is forwarded into the read data.
  always_comb begin
    rd_data = regs_q[idx];
    if (hw_wr_en && (hw_wr_addr == idx)) begin
      rd_data = hw_wr_data;
    end
  end

  always_comb begin
    slot_d   = slot_q;
    s_data_d = s_data_q;
    s_user_d = s_user_q;
    s_addr_d = s_addr_q;
    if (resp_en) begin
      slot_d      = SLOT_FULL;
      s_data_d    = (!is_wr && in_range) ? rd_data : '0;
      s_user_d    = '0;
      s_user_d[0] = !in_range;
      s_user_d[1] = is_wr;
      s_addr_d    = m_addr;
    end else if (s_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  // Bus write has priority over a hw write to the same register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      pulse_d[i] = accept && is_wr && in_range && (idx == IW'(i));
      regs_d[i]  = regs_q[i];
      if (pulse_d[i]) begin
        regs_d[i] = m_data;
      end else if (hw_wr_en && (hw_wr_addr == IW'(i))) begin
        regs_d[i] = hw_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= SLOT_EMPTY;
      s_data_q <= '0;
      s_user_q <= '0;
      s_addr_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      slot_q   <= slot_d;
      s_data_q <= s_data_d;
      s_user_q <= s_user_d;
      s_addr_q <= s_addr_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign s_data       = s_data_q;
  assign s_user       = s_user_q;
  assign s_addr       = s_addr_q;
  assign bus_wr_pulse = pulse_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign reg_q[gi*DW +: DW] = regs_q[gi];
  end

endmodule

// File: tb/tb_sra_reg_slave.sv
// Scoreboard bench for sra_reg_slave: stimulus pushes expected responses, a monitor pops and compares.
module tb_sra_reg_slave;

`ifdef SRA_REG_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         m_valid = 1'b0;
  logic         m_ready;
  logic [31:0]  m_data = '0;
  logic [1:0]   m_user = '0;
  logic [7:0]   m_addr = '0;
  logic         s_valid;
  logic         s_ready = 1'b1;
  logic [31:0]  s_data;
  logic [1:0]   s_user;
  logic [7:0]   s_addr;
  logic         hw_wr_en = 1'b0;
  logic [3:0]   hw_wr_addr = '0;
  logic [31:0]  hw_wr_data = '0;
  logic [511:0] reg_q;
  logic [15:0]  bus_wr_pulse;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  user;
    logic [7:0]  addr;
  } resp_t;

  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  sra_reg_slave dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user), .m_addr(m_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_user(s_user), .s_addr(s_addr),
    .hw_wr_en(hw_wr_en), .hw_wr_addr(hw_wr_addr), .hw_wr_data(hw_wr_data),
    .reg_q(reg_q), .bus_wr_pulse(bus_wr_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rq(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  // Monitor: a transfer occurs at the next posedge when s_valid && s_ready here.
  always @(negedge clk) begin
    if (!rst && s_valid && s_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got addr %h data %h user %b expected none", s_addr, s_data, s_user);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        $display("resp addr=%h data=%h user=%b", s_addr, s_data, s_user);
        chk("resp_data", s_data, e.data);
        chk("resp_user", {30'b0, s_user}, {30'b0, e.user});
        chk("resp_addr", {24'b0, s_addr}, {24'b0, e.addr});
      end
    end
  end

  // Issue one request; returns at posedge+1 after the accept edge.
  task automatic send(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [31:0] edata, input logic [1:0] euser);
    bit got;
    resp_t e;
    m_valid = 1'b1;
    m_user  = {1'b0, wr};
    m_addr  = addr;
    m_data  = data;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no m_ready expected accept of addr %h", addr);
    end else begin
      if (!wr || ACK) begin
        e.data = edata;
        e.user = euser;
        e.addr = addr;
        exp_q.push_back(e);
      end
      $display("req %s addr=%h data=%h", wr ? "WR" : "RD", addr, data);
      @(posedge clk);
      #1;
    end
    m_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [511:0] saved;
    int start;

    // Reset state
    idle(2);
    chk("rst_m_ready", {31'b0, m_ready}, 32'd1);
    chk("rst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_s_data", s_data, 32'd0);
    chk("rst_s_user_addr", {22'b0, s_user, s_addr}, 32'd0);
    chk("rst_regs", {31'b0, |reg_q}, 32'd0);
    chk("rst_pulse", {16'b0, bus_wr_pulse}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Write then read addr 3
    send(1'b1, 8'd3, 32'hDEADBEEF, 32'h0, 2'b10);
    chk("wr3_pulse_on", {16'b0, bus_wr_pulse}, 32'h0008);
    chk("wr3_reg", rq(3), 32'hDEADBEEF);
    send(1'b0, 8'd3, 32'h0, 32'hDEADBEEF, 2'b00);
    chk("wr3_pulse_off", {16'b0, bus_wr_pulse}, 32'h0000);
    idle(2);

    // Out of range
    send(1'b0, 8'd20, 32'h0, 32'h0, 2'b01);
    saved = reg_q;
    send(1'b1, 8'd20, 32'hCAFEF00D, 32'h0, 2'b11);
    chk("oor_pulse", {16'b0, bus_wr_pulse}, 32'h0);
    idle(1);
    chk("oor_no_change", {31'b0, reg_q == saved}, 32'd1);
    idle(2);

    // Stall with a queued request
    send(1'b1, 8'd1, 32'h55, 32'h0, 2'b10);
    idle(2);
    s_ready = 1'b0;
    send(1'b0, 8'd1, 32'h0, 32'h55, 2'b00);
    m_valid = 1'b1;
    m_user  = 2'b01;
    m_addr  = 8'd5;
    m_data  = 32'h77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_s_valid", {31'b0, s_valid}, 32'd1);
      chk("stall_s_data", s_data, 32'h55);
      chk("stall_m_ready", {31'b0, m_ready}, 32'd0);
      chk("stall_reg5", rq(5), 32'h0);
    end
    @(posedge clk);
    #1;
    s_ready = 1'b1;
    send(1'b1, 8'd5, 32'h77, 32'h0, 2'b10);
    chk("queued_reg5", rq(5), 32'h77);
    idle(2);

    // Bus vs hw write collision, then hw-only writes
    hw_wr_en = 1'b1; hw_wr_addr = 4'd2; hw_wr_data = 32'h2222;
    send(1'b1, 8'd2, 32'h1111, 32'h0, 2'b10);
    hw_wr_en = 1'b0;
    chk("collide_reg2", rq(2), 32'h1111);
    hw_wr_en = 1'b1; hw_wr_addr = 4'd4; hw_wr_data = 32'h3333;
    idle(1);
    hw_wr_en = 1'b0;
    chk("hw_reg4", rq(4), 32'h3333);
    chk("hw_no_resp", {31'b0, s_valid}, 32'd0);
    chk("hw_no_pulse", {16'b0, bus_wr_pulse}, 32'h0);
    hw_wr_en = 1'b1; hw_wr_addr = 4'd4; hw_wr_data = 32'h4444;
    send(1'b0, 8'd4, 32'h0, 32'h4444, 2'b00);
    hw_wr_en = 1'b0;
    idle(2);

    // Reset while a response is stalled
    s_ready = 1'b0;
    send(1'b0, 8'd2, 32'h0, 32'h1111, 2'b00);
    rst = 1'b1;
    exp_q.delete();
    idle(1);
    chk("mid_rst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("mid_rst_m_ready", {31'b0, m_ready}, 32'd1);
    chk("mid_rst_regs", {31'b0, |reg_q}, 32'd0);
    rst = 1'b0;
    s_ready = 1'b1;
    idle(4);
    chk("post_rst_s_valid", {31'b0, s_valid}, 32'd0);

    // Streaming: alternating write/read at full rate
    start = cyc;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(8 + i), 32'hA000_0000 + 32'(i), 32'h0, 2'b10);
      send(1'b0, 8'(8 + i), 32'h0, 32'hA000_0000 + 32'(i), 2'b00);
    end
    idle(1);
    chk("stream_cycles", 32'(cyc - start), 32'd9);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_s_valid", {31'b0, s_valid}, 32'd0);

    idle(3);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
